// File: rtl/matmul_pkg.sv
// Shared types and fixed-point helpers for the matrix-multiply engine.
package matmul_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    OUTPUT
  } state_t;

  // Wide enough for any accumulator this engine can be configured with.
  localparam int WIDE_W = 96;
  typedef logic signed [WIDE_W-1:0] wide_t;

  function automatic int acc_width(input int data_w, input int k);
    return 2 * data_w + $clog2(k) + 1;
  endfunction

  function automatic wide_t round_shift(input wide_t acc, input int frac_w);
    wide_t half;
    half = wide_t'(1) <<< (frac_w - 1);
    return (acc + half) >>> frac_w;
  endfunction

  function automatic wide_t round_sat(input wide_t acc, input int data_w, input int frac_w);
    wide_t r;
    wide_t max_v;
    wide_t min_v;
    wide_t res;
    r     = round_shift(acc, frac_w);
    max_v = (wide_t'(1) <<< (data_w - 1)) - wide_t'(1);
    min_v = -max_v - wide_t'(1);
    if (r > max_v)      res = max_v;
    else if (r < min_v) res = min_v;
    else                res = r;
    return res;
  endfunction

  function automatic logic saturates(input wide_t acc, input int data_w, input int frac_w);
    wide_t r;
    wide_t max_v;
    r     = round_shift(acc, frac_w);
    max_v = (wide_t'(1) <<< (data_w - 1)) - wide_t'(1);
    return (r > max_v) || (r < (-max_v - wide_t'(1)));
  endfunction

endpackage

// File: rtl/matmul_engine_fxp_mac.sv
// Registered signed multiply-accumulate; acc_next exposes the sum the next
// enabled edge will store, so the caller can round the final term without waiting.
module fxp_mac #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 34
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [ACC_W-1:0]  acc_next
);

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    acc;

  assign prod     = a * b;
  assign acc_next = acc + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   acc <= '0;
    else if (clr) acc <= '0;
    else if (en)  acc <= acc_next;
  end

endmodule

// File: rtl/matmul_engine.sv
// Sequential fixed-point Y = A*B: one MAC, K cycles per element, results
// streamed row-major over valid/ready with round-to-nearest and saturation.
module matmul_engine
  import matmul_pkg::*;
#(
  parameter  int M      = 2,
  parameter  int K      = 2,
  parameter  int N      = 2,
  parameter  int DATA_W = 16,
  parameter  int FRAC_W = 8,
  localparam int A_AW   = (M*K > 1) ? $clog2(M*K) : 1,
  localparam int B_AW   = (K*N > 1) ? $clog2(K*N) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_we,
  input  logic [A_AW-1:0]   a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  input  logic              b_we,
  input  logic [B_AW-1:0]   b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              y_valid,
  input  logic              y_ready,
  output logic [DATA_W-1:0] y_data,
  output logic              y_last,
  output logic              sat_flag
);

  // state   | meaning
  // IDLE    | operands writable, waiting for start
  // COMPUTE | accumulate A[i][k]*B[k][j], one k per cycle
  // OUTPUT  | hold y(i,j) stable until the consumer takes it

  localparam int ACC_W = acc_width(DATA_W, K);
  localparam int IW    = (M > 1) ? $clog2(M) : 1;
  localparam int JW    = (N > 1) ? $clog2(N) : 1;
  localparam int KW    = (K > 1) ? $clog2(K) : 1;

  state_t            state;
  logic [IW-1:0]     i;
  logic [JW-1:0]     j;
  logic [KW-1:0]     k;
  logic [DATA_W-1:0] a_mem [M*K];
  logic [DATA_W-1:0] b_mem [K*N];
  logic [A_AW-1:0]   a_idx;
  logic [B_AW-1:0]   b_idx;
  logic              mac_clr;
  logic              mac_en;
  logic [ACC_W-1:0]  acc_next;
  wide_t             acc_wide;
  logic              handshake;
  logic              last_elem;

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (state == IDLE && a_we && 32'(a_addr) < 32'(M*K)) a_mem[a_addr] <= a_wdata;
    if (state == IDLE && b_we && 32'(b_addr) < 32'(K*N)) b_mem[b_addr] <= b_wdata;
  end

  assign a_idx = A_AW'(32'(i) * K + 32'(k));
  assign b_idx = B_AW'(32'(k) * N + 32'(j));

  assign handshake = (state == OUTPUT) && y_ready;
  assign last_elem = (i == IW'(M-1)) && (j == JW'(N-1));
  assign mac_clr   = ((state == IDLE) && start) || handshake;
  assign mac_en    = (state == COMPUTE);

  fxp_mac #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (mac_clr),
    .en       (mac_en),
    .a        (a_mem[a_idx]),
    .b        (b_mem[b_idx]),
    .acc_next (acc_next)
  );

  assign acc_wide = {{(WIDE_W-ACC_W){acc_next[ACC_W-1]}}, acc_next};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      i        <= '0;
      j        <= '0;
      k        <= '0;
      done     <= 1'b0;
      y_valid  <= 1'b0;
      y_data   <= '0;
      y_last   <= 1'b0;
      sat_flag <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= COMPUTE;
            i        <= '0;
            j        <= '0;
            k        <= '0;
            sat_flag <= 1'b0;
          end
        end
        COMPUTE: begin
          // acc_next already includes the k == K-1 term at this edge
          if (k == KW'(K-1)) begin
            state    <= OUTPUT;
            k        <= '0;
            y_valid  <= 1'b1;
            y_data   <= DATA_W'(round_sat(acc_wide, DATA_W, FRAC_W));
            y_last   <= last_elem;
            sat_flag <= sat_flag | saturates(acc_wide, DATA_W, FRAC_W);
          end else begin
            k <= k + 1'b1;
          end
        end
        OUTPUT: begin
          if (y_ready) begin
            y_valid <= 1'b0;
            y_last  <= 1'b0;
            k       <= '0;
            if (last_elem) begin
              state <= IDLE;
              done  <= 1'b1;
            end else begin
              state <= COMPUTE;
              if (j == JW'(N-1)) begin
                j <= '0;
                i <= i + 1'b1;
              end else begin
                j <= j + 1'b1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
